wave_reader: RTL

Capture-side consumer for the trigger block. It waits for a completed 256-sample capture, copies the frozen capture array into a double-buffered, display-scaled waveform memory, and then re-arms the trigger. The display drawing logic reads per-column Y coordinates from this block. Bank swaps happen only at frame boundaries, so no frame ever shows a half-written trace.

---
 rtl/wave_reader_if.sv | 49 ++++
 rtl/wave_reader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wave_reader_if.sv
// rtl/wave_reader_if.sv - trigger-side and display-side signal bundle for wave_reader
//
// Purpose: groups the handshake and bus signals between wave_reader, the trigger
// block and the display drawing logic.
//
// Signals:
//   trigger_buffer  12 x [0:255] frozen capture array from the trigger
//   read            capture-complete flag from the trigger
//   ready           capture enable to the trigger
//   hold            run/stop; high blocks new capture requests
//   frame_start     one-cycle pulse at the start of each display frame
//   rd_addr         display column index 0..255
//   rd_y            registered scaled Y for rd_addr, from the display bank
//   trace_valid     high once a bank has been swapped in since reset
// Modports:
//   master  - trigger/display side (drives inputs of wave_reader)
//   slave   - wave_reader side
interface wave_reader_if;
    logic [11:0] trigger_buffer [0:255];
    logic        read;
    logic        ready;
    logic        hold;
    logic        frame_start;
    logic [7:0]  rd_addr;
    logic [9:0]  rd_y;
    logic        trace_valid;

    modport master (
        output trigger_buffer,
        output read,
        output hold,
        output frame_start,
        output rd_addr,
        input  ready,
        input  rd_y,
        input  trace_valid
    );

    modport slave (
        input  trigger_buffer,
        input  read,
        input  hold,
        input  frame_start,
        input  rd_addr,
        output ready,
        output rd_y,
        output trace_valid
    );
endinterface

// File: rtl/wave_reader.sv
// rtl/wave_reader.sv - double-buffered, display-scaled copy of the trigger capture array
//
// Purpose: waits for a completed 256-sample capture, copies it into the write bank
// as screen Y coordinates, swaps banks on the next frame boundary and re-arms the
// trigger. The display reads Y per column from the other (display) bank.
//
// Ports:
//   clk  - system clock (only clock)
//   rst  - synchronous, active-high reset
//   bus  - wave_reader_if.slave: trigger_buffer/read/ready/hold toward the trigger,
//          frame_start/rd_addr/rd_y/trace_valid toward the display
// Parameters:
//   SCALE_SHIFT - right shift applied to the inverted 12-bit sample
//   Y_OFFSET    - screen line added to the scaled value
module wave_reader #(
    parameter int unsigned SCALE_SHIFT = 4,
    parameter int unsigned Y_OFFSET    = 112
) (
    input  logic          clk,
    input  logic          rst,
    wave_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        ARM_LOW   = 2'd0,
        ARM_HIGH  = 2'd1,
        COPY      = 2'd2,
        SWAP_WAIT = 2'd3
    } state_t;

    localparam logic [9:0] Y_OFF = Y_OFFSET[9:0];

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic        wr_bank_q, wr_bank_d;
    logic        trace_valid_q, trace_valid_d;
    logic        ready_q, ready_d;
    logic [9:0]  rd_y_q, rd_y_d;

    logic [9:0]  bank0 [0:255];
    logic [9:0]  bank1 [0:255];

    logic        wr_en;
    logic [11:0] inv_sample;
    logic [11:0] shifted;
    logic [9:0]  wr_data;

    // Sample to screen line: top of screen is full scale, hence the inversion.
    always_comb begin
        inv_sample = 12'hFFF - bus.trigger_buffer[idx_q];
        shifted    = inv_sample >> SCALE_SHIFT;
        wr_data    = shifted[9:0] + Y_OFF;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        wr_bank_d     = wr_bank_q;
        trace_valid_d = trace_valid_q;
        ready_d       = 1'b0;
        wr_en         = 1'b0;

        case (state_q)
            ARM_LOW: begin
                // The trigger holds read high while disabled; only a low read
                // proves that a following high belongs to a fresh capture.
                if (!bus.hold) begin
                    ready_d = 1'b1;
                    if (!bus.read) begin
                        state_d = ARM_HIGH;
                    end
                end
            end
            ARM_HIGH: begin
                if (bus.hold) begin
                    state_d = ARM_LOW;
                end else if (bus.read) begin
                    state_d = COPY;
                    idx_d   = 8'd0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            COPY: begin
                wr_en = 1'b1;
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd255) begin
                    pending_d = 1'b1;
                    state_d   = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (bus.frame_start && pending_q) begin
                    wr_bank_d     = ~wr_bank_q;
                    pending_d     = 1'b0;
                    trace_valid_d = 1'b1;
                    state_d       = ARM_LOW;
                end
            end
            default: begin
                state_d = ARM_LOW;
            end
        endcase

        // Read through the next display bank so a swap is seen on the same edge.
        rd_y_d = wr_bank_d ? bank0[bus.rd_addr] : bank1[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARM_LOW;
            idx_q         <= 8'd0;
            pending_q     <= 1'b0;
            wr_bank_q     <= 1'b0;
            trace_valid_q <= 1'b0;
            ready_q       <= 1'b0;
            rd_y_q        <= 10'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            wr_bank_q     <= wr_bank_d;
            trace_valid_q <= trace_valid_d;
            ready_q       <= ready_d;
            rd_y_q        <= rd_y_d;
        end
    end

    // Bank contents are not reset; writes only ever target the write bank.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            if (wr_bank_q) begin
                bank1[idx_q] <= wr_data;
            end else begin
                bank0[idx_q] <= wr_data;
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.rd_y        = rd_y_q;
    assign bus.trace_valid = trace_valid_q;

endmodule
